// File: rtl/queen_pkg.sv
// Shared types for the 8-queen sequencer: state encoding, row sizing and the
// control bundle with its state decoder.
package queen_pkg;

   localparam int N_QUEENS = 8;
   localparam int ROW_W    = 3;

   typedef enum logic [3:0] {
      IDLE, CLEAR, LOAD, CHECK, PLACE, ADV, CONFLICT,
      BACK, POP, EMIT_RST, EMIT, DONE, FAIL
   } state_t;

   typedef struct packed {
      logic board_clear;
      logic shift_right;
      logic counter_reset;
      logic count_up;
      logic count_down;
      logic load_counter;
      logic count;
      logic enable_output;
      logic out_valid;
      logic busy;
      logic done;
      logic found;
   } ctl_t;

   // Status qualifiers only gate the strobe the current state owns,
   // so at most one counter command is ever active.
   function automatic ctl_t decode(
      input state_t s,
      input logic   lqz,
      input logic   lcell,
      input logic   safe,
      input logic   dcz,
      input logic   last_beat
   );
      ctl_t c;
      c      = '0;
      c.busy = (s != IDLE);
      unique case (s)
         CLEAR: begin
            c.board_clear   = 1'b1;
            c.counter_reset = 1'b1;
         end
         LOAD:     c.load_counter = !lqz;
         CHECK:    c.count        = safe && !dcz;
         PLACE:    c.count_up     = 1'b1;
         CONFLICT: c.shift_right  = !lcell;
         BACK:     c.shift_right  = 1'b1;
         POP:      c.count_down   = 1'b1;
         EMIT_RST: c.counter_reset = 1'b1;
         EMIT: begin
            c.enable_output = 1'b1;
            c.out_valid     = 1'b1;
            c.count_up      = !last_beat;
         end
         DONE: begin
            c.done  = 1'b1;
            c.found = 1'b1;
         end
         FAIL:    c.done = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/queen_controller_if.sv
// Controller <-> datapath/host bundle. master = controller side
// (drives strobes, reads status), slave = datapath/host side.
interface queen_controller_if;
   logic start;
   logic cout;
   logic down_counter_zero;
   logic last_queen_counter_zero;
   logic last_cell;
   logic safe;
   logic board_clear;
   logic shift_right;
   logic counter_reset;
   logic count_up;
   logic count_down;
   logic load_counter;
   logic count;
   logic enable_output;
   logic out_valid;
   logic busy;
   logic done;
   logic found;

   modport master (
      input  start, cout, down_counter_zero,
             last_queen_counter_zero, last_cell, safe,
      output board_clear, shift_right, counter_reset,
             count_up, count_down, load_counter, count,
             enable_output, out_valid, busy, done, found
   );

   modport slave (
      output start, cout, down_counter_zero,
             last_queen_counter_zero, last_cell, safe,
      input  board_clear, shift_right, counter_reset,
             count_up, count_down, load_counter, count,
             enable_output, out_valid, busy, done, found
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with sync reset and clear.
// Ports: clk, reset, clr, inc in; q [W-1:0] out.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/queen_controller.sv
// 8-queen backtracking sequencer: searches, then streams 8 rows on out_bus.
// Ports: clk, reset (sync, high), bus (queen_controller_if.master);
// step_count [STEP_W-1:0] only when QUEEN_STEP_COUNT_EN is defined.
module queen_controller
   import queen_pkg::*;
`ifdef QUEEN_STEP_COUNT_EN
#(
   parameter int STEP_W = 16
)
`endif
(
   input  logic                     clk,
   input  logic                     reset,
   queen_controller_if.master       bus
`ifdef QUEEN_STEP_COUNT_EN
   ,
   output logic [STEP_W-1:0]        step_count
`endif
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_QUEENS - 1);

   state_t           state;
   state_t           nxt;
   logic [ROW_W-1:0] beat;
   logic [ROW_W-1:0] nxt_beat;
   ctl_t             c;

   always_comb begin
      nxt      = state;
      nxt_beat = '0;
      unique case (state)
         IDLE:     if (bus.start) nxt = CLEAR;
         CLEAR:    nxt = LOAD;
         LOAD:     nxt = bus.last_queen_counter_zero ? PLACE : CHECK;
         CHECK: begin
            if (!bus.safe)                  nxt = CONFLICT;
            else if (bus.down_counter_zero) nxt = PLACE;
         end
         PLACE:    nxt = ADV;
         ADV:      nxt = bus.cout ? EMIT_RST : LOAD;
         CONFLICT: nxt = bus.last_cell ? BACK : LOAD;
         BACK:     nxt = bus.last_queen_counter_zero ? FAIL : POP;
         POP:      nxt = CONFLICT;
         EMIT_RST: nxt = EMIT;
         EMIT:     if (beat == LAST_ROW) nxt = DONE;
         DONE:     nxt = IDLE;
         FAIL:     nxt = IDLE;
         default:  nxt = IDLE;
      endcase
      // Beat counter tracks the emitted row independently of cout.
      if (state == EMIT) nxt_beat = beat + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         beat  <= '0;
      end else begin
         state <= nxt;
         beat  <= nxt_beat;
      end
   end

   always_comb begin
      c = decode(state,
                 bus.last_queen_counter_zero,
                 bus.last_cell,
                 bus.safe,
                 bus.down_counter_zero,
                 beat == LAST_ROW);
   end

   assign bus.board_clear   = c.board_clear;
   assign bus.shift_right   = c.shift_right;
   assign bus.counter_reset = c.counter_reset;
   assign bus.count_up      = c.count_up;
   assign bus.count_down    = c.count_down;
   assign bus.load_counter  = c.load_counter;
   assign bus.count         = c.count;
   assign bus.enable_output = c.enable_output;
   assign bus.out_valid     = c.out_valid;
   assign bus.busy          = c.busy;
   assign bus.done          = c.done;
   assign bus.found         = c.found;

`ifdef QUEEN_STEP_COUNT_EN
   sat_counter #(
      .W (STEP_W)
   ) u_steps (
      .clk   (clk),
      .reset (reset),
      .clr   (state == CLEAR),
      .inc   (state == CHECK),
      .q     (step_count)
   );
`endif

endmodule

// File: tb/tb_queen_controller.sv
// Bench for queen_controller: behavioural 8-queen datapath plus a
// scoreboard of expected out_bus beats and done/found events.
module tb_queen_controller;
   import queen_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   queen_controller_if bus();

`ifdef QUEEN_STEP_COUNT_EN
   logic [15:0] step_count;
   int          chk_cycles = 0;
`endif

   queen_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef QUEEN_STEP_COUNT_EN
      ,
      .step_count (step_count)
`endif
   );

   logic       sc_clr, sc_inc;
   logic [3:0] sc_q;
   sat_counter #(.W(4)) u_sat (
      .clk   (clk),
      .reset (reset),
      .clr   (sc_clr),
      .inc   (sc_inc),
      .q     (sc_q)
   );

   // datapath model
   logic [2:0] col [8];
   logic [3:0] lq;
   logic [2:0] oq;
   logic [2:0] ca, cb, dr, dc;
   bit         mock = 0;

   always @(posedge clk) begin
      if (reset || bus.board_clear) begin
         for (int i = 0; i < 8; i++) col[i] <= 3'd0;
      end else if (bus.shift_right) begin
         col[lq[2:0]] <= col[lq[2:0]] + 3'd1;
      end
      if (reset || bus.counter_reset) lq <= 4'd0;
      else if (bus.count_up)          lq <= lq + 4'd1;
      else if (bus.count_down)        lq <= lq - 4'd1;
      if (reset)                  oq <= 3'd0;
      else if (bus.load_counter)  oq <= lq[2:0] - 3'd1;
      else if (bus.count)         oq <= oq - 3'd1;
   end

   always_comb begin
      ca = col[lq[2:0]];
      cb = col[oq];
      dr = lq[2:0] - oq;
      dc = (ca > cb) ? ca - cb : cb - ca;
   end

   assign bus.safe      = mock ? 1'b0 : ((ca != cb) && (dc != dr));
   assign bus.last_cell = mock ? 1'b1 : (ca == 3'd7);
   assign bus.cout      = lq[3];
   assign bus.down_counter_zero       = (oq == 3'd0);
   assign bus.last_queen_counter_zero = (lq == 4'd0);

   wire [7:0] out_bus;
   assign out_bus = bus.enable_output ? (8'h80 >> ca) : 8'bz;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int viol = 0;
   logic [8:0] exp_q [$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] outs();
      return {bus.board_clear, bus.shift_right, bus.counter_reset,
              bus.count_up, bus.count_down, bus.load_counter, bus.count,
              bus.enable_output, bus.out_valid, bus.busy, bus.done,
              bus.found};
   endfunction

   task automatic push_solution();
      logic [7:0] rows [8];
      rows = '{8'h80, 8'h08, 8'h01, 8'h04, 8'h20, 8'h02, 8'h40, 8'h10};
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, rows[i]});
      exp_q.push_back(9'h101);
   endtask

   // monitor
   initial begin
      logic [8:0] act;
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if ($countones({bus.count_up, bus.count_down, bus.counter_reset,
                         bus.load_counter, bus.count}) > 1) viol++;
         if (bus.done) done_cnt++;
`ifdef QUEEN_STEP_COUNT_EN
         if (bus.board_clear) chk_cycles = 0;
         else if (dut.state == CHECK) chk_cycles++;
`endif
         if (bus.out_valid || bus.done) begin
            act = bus.done ? {1'b1, 7'd0, bus.found} : {1'b0, out_bus};
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected act=%0h exp=none", act);
            end else begin
               e = exp_q.pop_front();
               chk("sb_item", 32'(act), 32'(e));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(string nm, int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         cyc();
         n++;
      end
      chk({nm, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
   endtask

   initial begin
      int n;
      int beats;
      int d0;
      bit saw_load;

      reset     = 1'b1;
      bus.start = 1'b0;
      sc_clr    = 1'b0;
      sc_inc    = 1'b0;
      repeat (3) cyc();
      chk("reset_outs", 32'(outs()), 32'd0);
      reset = 1'b0;
      cyc();

      // full solve, row-0 skip, busy one cycle after start
      push_solution();
      pulse_start();
      chk("clear_busy", 32'({bus.busy, bus.board_clear, bus.counter_reset}),
          32'b111);
      saw_load = 0;
      n = 0;
      while (!bus.count_up && n < 20) begin
         if (bus.load_counter) saw_load = 1;
         cyc();
         n++;
      end
      chk("row0_no_load", 32'({saw_load, bus.count_up}), 32'b01);
      wait_done("solve", 30000);
`ifdef QUEEN_STEP_COUNT_EN
      chk("step_count", 32'(step_count), 32'(chk_cycles));
      chk("step_nonzero", 32'(chk_cycles > 0), 32'd1);
`endif
      chk("solve_q_empty", 32'(exp_q.size()), 32'd0);
      cyc();
      chk("idle_after_solve", 32'(outs()), 32'd0);

      // exhaust with mock datapath
      mock = 1;
      exp_q.push_back(9'h100);
      pulse_start();
      wait_done("exhaust", 200);
      chk("exhaust_q_empty", 32'(exp_q.size()), 32'd0);
      mock = 0;
      cyc();

      // reset during third emitted beat
      exp_q.push_back({1'b0, 8'h80});
      exp_q.push_back({1'b0, 8'h08});
      exp_q.push_back({1'b0, 8'h01});
      d0 = done_cnt;
      pulse_start();
      beats = 0;
      n = 0;
      while (beats < 3 && n < 30000) begin
         if (bus.out_valid) beats++;
         if (beats < 3) begin
            cyc();
            n++;
         end
      end
      chk("abort_reached_beat3", 32'(beats), 32'd3);
      reset = 1'b1;
      cyc();
      chk("abort_outs", 32'(outs()), 32'd0);
      reset = 1'b0;
      repeat (3) cyc();
      chk("abort_no_done", 32'(done_cnt), 32'(d0));
      chk("abort_q_empty", 32'(exp_q.size()), 32'd0);

      push_solution();
      pulse_start();
      wait_done("resolve", 30000);
      chk("resolve_q_empty", 32'(exp_q.size()), 32'd0);
      cyc();

      // start held through the search
      push_solution();
      d0 = done_cnt;
      bus.start = 1'b1;
      n = 0;
      while (!bus.done && n < 30000) begin
         cyc();
         n++;
      end
      bus.start = 1'b0;
      repeat (20) cyc();
      chk("held_one_done", 32'(done_cnt - d0), 32'd1);
      chk("held_idle", 32'(bus.busy), 32'd0);
      chk("held_q_empty", 32'(exp_q.size()), 32'd0);

      // reset wins over start
      reset     = 1'b1;
      bus.start = 1'b1;
      cyc();
      reset     = 1'b0;
      bus.start = 1'b0;
      chk("rst_start_idle", 32'({bus.busy, bus.board_clear}), 32'd0);
      cyc();
      chk("rst_start_idle2", 32'(bus.busy), 32'd0);

      // saturating counter at width 4
      sc_clr = 1'b1;
      cyc();
      sc_clr = 1'b0;
      chk("sat_clr", 32'(sc_q), 32'd0);
      sc_inc = 1'b1;
      repeat (5) cyc();
      chk("sat_five", 32'(sc_q), 32'd5);
      repeat (15) cyc();
      sc_inc = 1'b0;
      chk("sat_max", 32'(sc_q), 32'd15);
      sc_clr = 1'b1;
      cyc();
      sc_clr = 1'b0;
      chk("sat_reclr", 32'(sc_q), 32'd0);

      chk("one_counter_ctl", 32'(viol), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
